adc_spi_responder: RTL and testbench
====================================

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 12: sample width.
- LEAD_Z, 4: leading zero bits per frame.
- FRAME_BITS, 16: SCLK periods per frame; must equal LEAD_Z+DATA_W.

REQ-002 Ports SHALL be:

| Name | Dir | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | 50 MHz system clock |
| reset | in | 1 | asynchronous, active-high reset |
| adc_cs | in | 1 | chip select from master, active-low, asynchronous to clk |
| adc_clk | in | 1 | serial clock from master, idles high, asynchronous to clk |
| adc_so | out | 1 | serial data to master |
| sample_data | in | DATA_W | next sample to serve |
| sample_valid | in | 1 | sample_data valid |
| sample_ready | out | 1 | holding register empty |
| pattern_en | in | 1 | serve internal ramp instead of sample_data |
| frame_done | out | 1 | one-clk pulse, complete frame |
| frame_err | out | 1 | one-clk pulse, frame aborted by early CS rise |
| underrun | out | 1 | one-clk pulse, frame started with empty holding register |
| frame_cnt | out | 16 | completed-frame counter |

REQ-003 The block SHALL use one clock (clk); reset SHALL be asynchronous and active-high.

Function
REQ-004 adc_cs and adc_clk SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized signals with a third register.
REQ-005 Supported adc_clk frequency SHALL be at most clk/8; each adc_clk level SHALL last at least 4 clk.
REQ-006 A handshake SHALL occur when sample_valid && sample_ready.
- On a handshake, sample_data SHALL be stored in the holding register.
- sample_ready SHALL be 1 exactly when the holding register is empty.
REQ-007 The FSM SHALL have states IDLE, SHIFT and WAIT_CS.
REQ-008 In IDLE, a synchronized CS falling edge SHALL cause the following, then a transition to SHIFT with bit index 0:
- Frame word {LEAD_Z zeros, sample} is loaded into a shift register.
- The sample is taken from the holding register, which is then marked empty.
REQ-009 If the holding register is empty at CS fall and pattern_en=0, the last served sample SHALL be reused and underrun SHALL pulse.
REQ-010 If pattern_en=1 at CS fall, the sample SHALL be the ramp counter.
- The holding register SHALL be left untouched.
- The ramp SHALL increment by 1 per completed frame and wrap from 2^DATA_W-1 to 0.
REQ-011 adc_so SHALL present the frame MSB starting 3 clk after the raw CS falling edge.
REQ-012 Each synchronized adc_clk falling edge SHALL shift the next bit onto adc_so, 3 clk after the raw edge.
REQ-013 Each synchronized adc_clk rising edge SHALL increment the bit index; the 16th rising edge SHALL cause all of:
- transition to WAIT_CS;
- a frame_done pulse;
- frame_cnt increments, wrapping 0xFFFF to 0.
REQ-014 In WAIT_CS, extra adc_clk edges SHALL be ignored and adc_so SHALL be 0; a CS rise SHALL return the FSM to IDLE.
REQ-015 A CS rise while in SHIFT SHALL cause:
- a frame_err pulse and a transition to IDLE;
- no frame_cnt increment and no ramp advance;
- the consumed sample is not restored.
REQ-016 adc_so SHALL be 0 in IDLE.
REQ-017 When a CS fall and a handshake occur in the same clk, the CS load SHALL use the prior holding content.
- If the holding register was empty, the underrun rule applies.
- The new sample SHALL be stored and sample_ready SHALL go 0.
REQ-018 frame_done, frame_err and underrun SHALL be registered one-clk pulses and SHALL never assert in the same clk.

Reset
REQ-019 On reset, all of the following SHALL hold:
- FSM in IDLE;
- adc_so=0 and sample_ready=1;
- holding register empty, last sample 0, ramp 0;
- frame_cnt=0;
- all pulse outputs 0;
- synchronizers set to CS=1 and adc_clk=1.
REQ-020 Reset asserted mid-frame SHALL abort silently, with no frame_err pulse.
REQ-021 After reset release with adc_cs already low, no frame SHALL start until a CS rise followed by a CS fall.

Structure
REQ-022 A shared package SHALL hold the FSM state enumeration and the default values for DATA_W, LEAD_Z and FRAME_BITS.
REQ-023 The 2-flop-plus-edge synchronizer SHALL be one sub-module, sync_edge, instantiated once for adc_cs and once for adc_clk.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Basic frame: handshake 0xA5C, then a 16-clock frame with SCLK=clk/8 → master samples 0x0A5C; frame_done pulses once; frame_cnt=1.
- Pattern mode: pattern_en=1, three frames → data 0x000, 0x001, 0x002; sample_ready stays 1.
- Underrun: sample 0x123 served, then a second frame with no new sample → second frame returns 0x123; underrun pulses once.
- Abort: CS rises after 7 SCLK → frame_err pulses; frame_cnt unchanged; the next frame with ramp gives the same ramp value.
- Ramp/counter wrap: frame_cnt preloaded by 65535 frames, or the ramp at 0xFFF → next values wrap to 0.
- Reset mid-frame: reset asserted with CS low → adc_so=0 and IDLE; no frame until CS goes high then low.

Source files
------------

// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the ADC SPI responder: default frame geometry and FSM states.
package adc_spi_responder_pkg;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_LEAD_Z     = 4;
  localparam int DEF_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pins plus sample-stream handshake of the ADC responder, seen from master and slave side.
interface adc_spi_responder_if
  import adc_spi_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              adc_cs;
  logic              adc_clk;
  logic              adc_so;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              pattern_en;

  modport master (
    output adc_cs, adc_clk, sample_data, sample_valid, pattern_en,
    input  adc_so, sample_ready
  );

  modport slave (
    input  adc_cs, adc_clk, sample_data, sample_valid, pattern_en,
    output adc_so, sample_ready
  );
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// Two-flop synchronizer with a third register for edge detection on an asynchronous input.
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic       s1, s2, s3;
  logic [1:0] settle;
  logic       seen_high;

  // Edges are only trusted once the chain holds real pin samples, and a fall
  // only counts after the line was seen high, so a line already low at reset
  // release cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= RESET_VAL;
      s2        <= RESET_VAL;
      s3        <= RESET_VAL;
      settle    <= '0;
      seen_high <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      settle <= {settle[0], 1'b1};
      if (settle[1] && s2) seen_high <= 1'b1;
    end
  end

  assign rise = settle[1] & s2 & ~s3;
  assign fall = seen_high & ~s2 & s3;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave that serves one {leading zeros, sample} frame per chip-select, from a
// single-entry holding register or an internal ramp.
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEAD_Z     = DEF_LEAD_Z,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_cs,
  input  logic              adc_clk,
  output logic              adc_so,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              pattern_en,
  output logic              frame_done,
  output logic              frame_err,
  output logic              underrun,
  output logic [15:0]       frame_cnt
);
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk, .reset, .din(adc_cs), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sclk_sync (
    .clk, .reset, .din(adc_clk), .rise(sclk_rise), .fall(sclk_fall)
  );

  state_t                state, state_n;
  logic                  start, finish, abort;
  logic [IDX_W-1:0]      bit_idx;
  logic [FRAME_BITS-2:0] shreg;
  logic [DATA_W-1:0]     hold_data, last_data, ramp, served;
  logic                  hold_full, take, starve;
  logic [FRAME_BITS-1:0] frame_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) begin
        start   = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: if (cs_rise) begin
        abort   = 1'b1;
        state_n = IDLE;
      end else if (sclk_rise && bit_idx == LAST_IDX) begin
        finish  = 1'b1;
        state_n = WAIT_CS;
      end
      WAIT_CS: if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Source selection for the frame about to start; uses the holding content as
  // it stands before any handshake in the same cycle.
  always_comb begin
    served = last_data;
    take   = 1'b0;
    starve = 1'b0;
    if (pattern_en) begin
      served = ramp;
    end else if (hold_full) begin
      served = hold_data;
      take   = 1'b1;
    end else begin
      starve = 1'b1;
    end
  end

  assign frame_word   = {{LEAD_Z{1'b0}}, served};
  assign sample_ready = ~hold_full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_so     <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      last_data  <= '0;
      ramp       <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= finish;
      frame_err  <= abort;
      underrun   <= start & starve;

      if (start) begin
        adc_so  <= frame_word[FRAME_BITS-1];
        shreg   <= frame_word[FRAME_BITS-2:0];
        bit_idx <= '0;
        if (take) last_data <= hold_data;
      end else if (state_n != SHIFT) begin
        adc_so <= 1'b0;
      end else if (sclk_fall) begin
        adc_so <= shreg[FRAME_BITS-2];
        shreg  <= {shreg[FRAME_BITS-3:0], 1'b0};
      end

      if (state == SHIFT && sclk_rise) bit_idx <= bit_idx + 1'b1;

      if (finish) begin
        frame_cnt <= frame_cnt + 16'd1;
        ramp      <= ramp + 1'b1;
      end

      // The register is never full and taken in the same cycle, since a
      // handshake needs it empty.
      if (sample_valid && !hold_full) begin
        hold_data <= sample_data;
        hold_full <= 1'b1;
      end else if (start && take) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench: an SPI master model reads frames at SCLK = clk/8 and compares
// against hand-computed words, pulse counts and counters.
module tb_adc_spi_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        frame_done, frame_err, underrun;
  logic [15:0] frame_cnt;
  logic        so4, ready4, done4, err4, under4;
  logic [15:0] frame_cnt4;

  int total = 0;
  int bad   = 0;
  int done_n = 0, err_n = 0, under_n = 0, multi_n = 0;

  always #5 clk = ~clk;

  adc_spi_responder_if #(.DATA_W(12)) bus ();

  adc_spi_responder u_dut (
    .clk(clk), .reset(reset),
    .adc_cs(bus.adc_cs), .adc_clk(bus.adc_clk), .adc_so(bus.adc_so),
    .sample_data(bus.sample_data), .sample_valid(bus.sample_valid),
    .sample_ready(bus.sample_ready), .pattern_en(bus.pattern_en),
    .frame_done(frame_done), .frame_err(frame_err), .underrun(underrun),
    .frame_cnt(frame_cnt)
  );

  // Narrow-ramp copy sharing the SPI lines, so the ramp wrap is reachable quickly.
  adc_spi_responder #(.DATA_W(4), .LEAD_Z(12), .FRAME_BITS(16)) u_dut4 (
    .clk(clk), .reset(reset),
    .adc_cs(bus.adc_cs), .adc_clk(bus.adc_clk), .adc_so(so4),
    .sample_data(4'h0), .sample_valid(1'b0), .sample_ready(ready4),
    .pattern_en(1'b1), .frame_done(done4), .frame_err(err4), .underrun(under4),
    .frame_cnt(frame_cnt4)
  );

  always @(negedge clk) begin
    if (frame_done) done_n++;
    if (frame_err)  err_n++;
    if (underrun)   under_n++;
    if (32'(frame_done) + 32'(frame_err) + 32'(underrun) > 1) multi_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
  endtask

  task automatic push(input logic [11:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    wait_clks(1);
    bus.sample_valid = 1'b0;
  endtask

  task automatic sclk_cycle();
    bus.adc_clk = 1'b0;
    wait_clks(4);
    bus.adc_clk = 1'b1;
    wait_clks(4);
  endtask

  // Master samples adc_so as it drives SCLK low, before the slave shifts.
  task automatic run_frame(input int nclk, input bit fall_push, input logic [11:0] d,
                           output logic [15:0] word, output logic [15:0] word4);
    word  = '0;
    word4 = '0;
    bus.adc_cs = 1'b0;
    if (fall_push) begin
      wait_clks(2);
      push(d);
      wait_clks(1);
    end else begin
      wait_clks(4);
    end
    for (int i = 0; i < nclk; i++) begin
      word  = {word[14:0], bus.adc_so};
      word4 = {word4[14:0], so4};
      sclk_cycle();
    end
    bus.adc_cs = 1'b1;
    wait_clks(6);
  endtask

  typedef struct {
    bit          rst;
    bit          push;
    bit          fall_push;
    bit          pat;
    logic [11:0] data;
    int          nclk;
    logic [15:0] word;
    int          done;
    int          err;
    int          under;
    logic [15:0] cnt;
    bit          rdy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w, w4;
    int d0, e0, u0, so_seen;

    vecs[0]  = '{1, 1, 0, 0, 12'hA5C, 16, 16'h0A5C, 1, 0, 0, 16'd1, 1};
    vecs[1]  = '{1, 0, 0, 1, 12'h000, 16, 16'h0000, 1, 0, 0, 16'd1, 1};
    vecs[2]  = '{0, 0, 0, 1, 12'h000, 16, 16'h0001, 1, 0, 0, 16'd2, 1};
    vecs[3]  = '{0, 0, 0, 1, 12'h000, 16, 16'h0002, 1, 0, 0, 16'd3, 1};
    vecs[4]  = '{1, 1, 0, 0, 12'h123, 16, 16'h0123, 1, 0, 0, 16'd1, 1};
    vecs[5]  = '{0, 0, 0, 0, 12'h000, 16, 16'h0123, 1, 0, 1, 16'd2, 1};
    vecs[6]  = '{0, 1, 0, 0, 12'hFFF, 16, 16'h0FFF, 1, 0, 0, 16'd3, 1};
    vecs[7]  = '{1, 0, 0, 1, 12'h000, 16, 16'h0000, 1, 0, 0, 16'd1, 1};
    vecs[8]  = '{0, 0, 0, 1, 12'h000,  7, 16'h0000, 0, 1, 0, 16'd1, 1};
    vecs[9]  = '{0, 0, 0, 1, 12'h000, 16, 16'h0001, 1, 0, 0, 16'd2, 1};
    vecs[10] = '{0, 1, 0, 0, 12'h3C3,  7, 16'h0000, 0, 1, 0, 16'd2, 1};
    vecs[11] = '{0, 0, 0, 0, 12'h000, 16, 16'h03C3, 1, 0, 1, 16'd3, 1};
    vecs[12] = '{1, 1, 0, 1, 12'h7E1, 16, 16'h0000, 1, 0, 0, 16'd1, 0};
    vecs[13] = '{0, 0, 0, 0, 12'h000, 16, 16'h07E1, 1, 0, 0, 16'd2, 1};
    vecs[14] = '{1, 0, 1, 0, 12'h456, 16, 16'h0000, 1, 0, 1, 16'd1, 0};
    vecs[15] = '{0, 0, 0, 0, 12'h000, 16, 16'h0456, 1, 0, 0, 16'd2, 1};

    reset            = 1'b1;
    bus.adc_cs       = 1'b1;
    bus.adc_clk      = 1'b1;
    bus.sample_data  = '0;
    bus.sample_valid = 1'b0;
    bus.pattern_en   = 1'b0;
    wait_clks(3);
    check("reset_so", 32'(bus.adc_so), 32'd0);
    check("reset_ready", 32'(bus.sample_ready), 32'd1);
    check("reset_cnt", 32'(frame_cnt), 32'd0);
    check("reset_pulses", {29'd0, frame_done, frame_err, underrun}, 32'd0);
    reset = 1'b0;
    wait_clks(3);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      bus.pattern_en = vecs[i].pat;
      if (vecs[i].push) push(vecs[i].data);
      d0 = done_n; e0 = err_n; u0 = under_n;
      run_frame(vecs[i].nclk, vecs[i].fall_push, vecs[i].data, w, w4);
      if (vecs[i].nclk == 16) check($sformatf("v%0d_word", i), 32'(w), 32'(vecs[i].word));
      check($sformatf("v%0d_done", i), done_n - d0, vecs[i].done);
      check($sformatf("v%0d_err", i), err_n - e0, vecs[i].err);
      check($sformatf("v%0d_underrun", i), under_n - u0, vecs[i].under);
      check($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_ready", i), 32'(bus.sample_ready), 32'(vecs[i].rdy));
    end

    // Bit latency: 0x800 puts the first 1 on adc_so after the 4th SCLK fall, 3 clk late.
    do_reset();
    bus.pattern_en = 1'b0;
    push(12'h800);
    bus.adc_cs = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 3; i++) sclk_cycle();
    bus.adc_clk = 1'b0;
    wait_clks(2);
    check("lat_before", 32'(bus.adc_so), 32'd0);
    wait_clks(1);
    check("lat_at3", 32'(bus.adc_so), 32'd1);
    wait_clks(1);
    bus.adc_clk = 1'b1;
    wait_clks(4);
    for (int i = 0; i < 12; i++) sclk_cycle();
    bus.adc_cs = 1'b1;
    wait_clks(6);
    check("lat_cnt", 32'(frame_cnt), 32'd1);

    // Reset mid-frame with CS held low: silent abort, no frame until CS toggles.
    do_reset();
    bus.pattern_en = 1'b1;
    e0 = err_n; d0 = done_n;
    bus.adc_cs = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 5; i++) sclk_cycle();
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
    check("rst_mid_so", 32'(bus.adc_so), 32'd0);
    check("rst_mid_cnt", 32'(frame_cnt), 32'd0);
    so_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.adc_so) so_seen++;
      sclk_cycle();
    end
    check("rst_mid_no_frame", done_n - d0, 0);
    check("rst_mid_no_err", err_n - e0, 0);
    check("rst_mid_so_quiet", so_seen, 0);
    bus.adc_cs = 1'b1;
    wait_clks(6);
    run_frame(16, 1'b0, 12'h000, w, w4);
    check("rst_mid_next_word", 32'(w), 32'h0000);
    check("rst_mid_next_done", done_n - d0, 1);

    // Ramp wrap on the 4-bit instance: 0..15 then back to 0.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      run_frame(16, 1'b0, 12'h000, w, w4);
      check($sformatf("wrap_ramp%0d", k), 32'(w4), 32'(k % 16));
    end
    check("wrap_cnt4", 32'(frame_cnt4), 32'd17);
    check("wrap_cnt", 32'(frame_cnt), 32'd17);

    check("pulses_exclusive", multi_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
